// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the byte-serial instruction fetch unit:
//   - fetch_state_t     : FETCH / HOLD / HALT controller states
//   - DEFAULT_HALT_WORD : instruction word that stops fetch by default
//   - pc_is_bad()       : start-of-fetch PC legality check
// ----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

    // A fetch may only start on a word-aligned PC whose last byte is still
    // inside the memory. Aligned PCs never wrap when 3 is added, so 32-bit
    // arithmetic is sufficient here.
    function automatic logic pc_is_bad(input logic [31:0] pc,
                                       input logic [31:0] mem_bytes);
        logic misaligned;
        logic past_end;
        misaligned = (pc[1:0] != 2'b00);
        past_end   = ((pc + 32'd3) >= mem_bytes);
        return misaligned | past_end;
    endfunction

endpackage

// File: rtl/fetch_unit_assembler.sv
// ----------------------------------------------------------------------------
// instr_assembler
// Collects four bytes, most significant first, into a 32-bit word.
// Ports:
//   clk       : clock
//   clear     : zero the word and the byte counter (wins over shift_en)
//   shift_en  : latch data_in into the slot selected by byte_cnt
//   data_in   : byte from instruction memory
//   byte_cnt  : index of the next byte to latch (0..3, wraps after 3)
//   word      : registered assembled word
//   word_next : word as it will look after latching data_in this cycle
// ----------------------------------------------------------------------------
module instr_assembler (
    input  logic        clk,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  data_in,
    output logic [1:0]  byte_cnt,
    output logic [31:0] word,
    output logic [31:0] word_next
);

    logic [1:0]  cnt_r;
    logic [31:0] word_r;

    // Merge the incoming byte into its big-endian slot
    always_comb begin
        word_next = word_r;
        case (cnt_r)
            2'd0:    word_next[31:24] = data_in;
            2'd1:    word_next[23:16] = data_in;
            2'd2:    word_next[15:8]  = data_in;
            2'd3:    word_next[7:0]   = data_in;
            default: word_next        = word_r;
        endcase
    end

    // Byte counter and word register; clear has priority over shift
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_r  <= 2'd0;
            word_r <= 32'd0;
        end else if (shift_en) begin
            cnt_r  <= cnt_r + 2'd1;
            word_r <= word_next;
        end else begin
            cnt_r  <= cnt_r;
            word_r <= word_r;
        end
    end

    assign byte_cnt = cnt_r;
    assign word     = word_r;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Fetches 32-bit big-endian instructions one byte per cycle from a byte-wide
// combinational memory and presents them with a valid/ready handshake.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   mem_addr/mem_data : byte address out, byte read back in the same cycle
//   instr, instr_pc   : presented instruction and its byte address
//   instr_valid       : instr/instr_pc valid; held until instr_ready
//   instr_ready       : downstream accepts the presented instruction
//   redirect_valid/_target : taken branch, restart fetch at target
//   halt, fault       : sticky stop indications (fault = bad PC)
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [$clog2(MEM_BYTES)-1:0] mem_addr,
    input  logic [7:0]                   mem_data,
    output logic [31:0]                  instr,
    output logic [31:0]                  instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_target,
    output logic                         halt,
    output logic                         fault
);

    localparam int          AW          = $clog2(MEM_BYTES);
    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;

    logic [31:0] pc_r;
    logic [31:0] pc_nxt_s;
    logic [31:0] instr_pc_r;
    logic [31:0] instr_pc_nxt_s;
    logic        valid_r;
    logic        valid_nxt_s;
    logic        halt_r;
    logic        halt_nxt_s;
    logic        fault_r;
    logic        fault_nxt_s;

    logic        asm_clear_s;
    logic        asm_shift_s;
    logic [1:0]  byte_cnt_s;
    logic [31:0] word_s;
    logic [31:0] word_next_s;

    logic        bad_pc_s;
    logic        last_byte_s;
    logic        is_halt_word_s;

    // PC legality only matters before the first byte of a fetch is consumed
    assign bad_pc_s       = (byte_cnt_s == 2'd0) && pc_is_bad(pc_r, MEM_BYTES_W);
    assign last_byte_s    = (byte_cnt_s == 2'd3);
    assign is_halt_word_s = (word_next_s == HALT_WORD);

    instr_assembler u_asm (
        .clk       (clk),
        .clear     (reset | asm_clear_s),
        .shift_en  (asm_shift_s),
        .data_in   (mem_data),
        .byte_cnt  (byte_cnt_s),
        .word      (word_s),
        .word_next (word_next_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; redirect outranks every other event outside HALT
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    state_nxt_s = ST_FETCH;
                end else if (bad_pc_s) begin
                    state_nxt_s = ST_HALT;
                end else if (last_byte_s) begin
                    state_nxt_s = is_halt_word_s ? ST_HALT : ST_HOLD;
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (redirect_valid || instr_ready) begin
                    state_nxt_s = ST_FETCH;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_HALT;
        endcase
    end

    // Output/datapath decode: next register values and assembler strobes
    always_comb begin
        pc_nxt_s       = pc_r;
        instr_pc_nxt_s = instr_pc_r;
        valid_nxt_s    = valid_r;
        halt_nxt_s     = halt_r;
        fault_nxt_s    = fault_r;
        asm_clear_s    = 1'b0;
        asm_shift_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_target;
                    valid_nxt_s = 1'b0;
                    asm_clear_s = 1'b1;
                end else if (bad_pc_s) begin
                    // No byte is latched for a fetch that never starts
                    valid_nxt_s = 1'b0;
                    halt_nxt_s  = 1'b1;
                    fault_nxt_s = 1'b1;
                end else begin
                    asm_shift_s = 1'b1;
                    if (last_byte_s && !is_halt_word_s) begin
                        valid_nxt_s    = 1'b1;
                        instr_pc_nxt_s = pc_r;
                    end else if (last_byte_s) begin
                        // Halt word: stop without ever presenting it
                        valid_nxt_s = 1'b0;
                        halt_nxt_s  = 1'b1;
                    end else begin
                        valid_nxt_s = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt_s    = redirect_target;
                    valid_nxt_s = 1'b0;
                    asm_clear_s = 1'b1;
                end else if (instr_ready) begin
                    pc_nxt_s    = pc_r + 32'd4;
                    valid_nxt_s = 1'b0;
                    asm_clear_s = 1'b1;
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            ST_HALT: begin
                valid_nxt_s = 1'b0;
                halt_nxt_s  = 1'b1;
            end
            default: begin
                valid_nxt_s = 1'b0;
                halt_nxt_s  = 1'b1;
                fault_nxt_s = 1'b1;
                asm_clear_s = 1'b1;
            end
        endcase
    end

    // Architectural registers; reset outranks every other event
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r       <= RESET_PC;
            instr_pc_r <= 32'd0;
            valid_r    <= 1'b0;
            halt_r     <= 1'b0;
            fault_r    <= 1'b0;
        end else begin
            pc_r       <= pc_nxt_s;
            instr_pc_r <= instr_pc_nxt_s;
            valid_r    <= valid_nxt_s;
            halt_r     <= halt_nxt_s;
            fault_r    <= fault_nxt_s;
        end
    end

    // Memory address: walk the bytes while fetching, otherwise park on pc
    always_comb begin
        if (state_r == ST_FETCH) begin
            mem_addr = pc_r[AW-1:0] + AW'(byte_cnt_s);
        end else begin
            mem_addr = pc_r[AW-1:0];
        end
    end

    assign instr       = word_s;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = valid_r;
    assign halt        = halt_r;
    assign fault       = fault_r;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          MEMB   = 128;
    localparam logic [31:0] HALT_W = 32'h0000_000C;

    logic        clk;
    logic        reset;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt;
    logic        fault;

    logic [7:0]  mem [0:MEMB-1];
    int          n_vec;
    int          n_err;

    fetch_unit #(
        .MEM_BYTES (MEMB),
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt            (halt),
        .fault           (fault)
    );

    assign mem_data = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        h;
        logic        f;
        logic [6:0]  addr;
        logic        chk_i;
    } vec_t;

    vec_t tab[$];

    // reference model state (transaction level)
    logic [31:0] m_pc;
    int          m_el;
    logic        m_valid;
    logic        m_halt;
    logic        m_fault;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic r, input logic rd, input logic rv, input logic [31:0] t);
        @(negedge clk);
        reset           = r;
        instr_ready     = rd;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] ipc, input logic h, input logic f,
                             input logic [6:0] a, input logic ci);
        chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
        chk({tag, ".halt"},  32'(halt),        32'(h));
        chk({tag, ".fault"}, 32'(fault),       32'(f));
        chk({tag, ".addr"},  32'(mem_addr),    32'(a));
        if (ci) begin
            chk({tag, ".instr"},    instr,    ins);
            chk({tag, ".instr_pc"}, instr_pc, ipc);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic rdy, input logic rv,
                                input logic [31:0] tgt, input logic v, input logic [31:0] ins,
                                input logic [31:0] ipc, input logic h, input logic f,
                                input int a, input logic ci);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.rv = rv; r.tgt = tgt; r.valid = v;
        r.ins = ins; r.ipc = ipc; r.h = h; r.f = f; r.addr = 7'(a); r.chk_i = ci;
        return r;
    endfunction

    // not-valid row with no reset
    function automatic vec_t nv(input logic rdy, input logic rv, input logic [31:0] tgt,
                                input logic h, input logic f, input int a);
        return mk(1'b0, rdy, rv, tgt, 1'b0, 32'd0, 32'd0, h, f, a, 1'b0);
    endfunction

    // valid row with no reset/redirect
    function automatic vec_t vv(input logic rdy, input logic [31:0] ins, input logic [31:0] ipc, input int a);
        return mk(1'b0, rdy, 1'b0, 32'd0, 1'b1, ins, ipc, 1'b0, 1'b0, a, 1'b1);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        int b;
        b = int'(a[6:0]);
        if (b > MEMB - 4) return 32'd0;
        return {mem[b], mem[b+1], mem[b+2], mem[b+3]};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        for (int i = 0; i < MEMB; i++) mem[i] = 8'hFF;
        {mem[0], mem[1], mem[2], mem[3]}     = 32'h2108_0002;
        {mem[4], mem[5], mem[6], mem[7]}     = 32'h010A_4020;
        {mem[8], mem[9], mem[10], mem[11]}   = 32'h1122_3344;
        {mem[12], mem[13], mem[14], mem[15]} = 32'h0000_000C;
        {mem[124], mem[125], mem[126], mem[127]} = 32'h5AA5_C33C;

        // ---------------- table-driven directed run ----------------
        tab.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 3));
        tab.push_back(vv(1'b1, 32'h2108_0002, 32'd0, 0));            // cycle 4
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4));         // accepted
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 7));
        tab.push_back(vv(1'b1, 32'h010A_4020, 32'd4, 4));            // cycle 9
        tab.push_back(vv(1'b0, 32'h010A_4020, 32'd4, 4));            // stall x3
        tab.push_back(vv(1'b0, 32'h010A_4020, 32'd4, 4));
        tab.push_back(vv(1'b0, 32'h010A_4020, 32'd4, 4));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8));         // accept -> pc 8
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 9));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 10));        // byte_cnt 2
        tab.push_back(nv(1'b1, 1'b1, 32'd4, 1'b0, 1'b0, 4));         // redirect to 4
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 5));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 6));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 7));
        tab.push_back(vv(1'b1, 32'h010A_4020, 32'd4, 4));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 8));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 9));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 10));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 11));
        tab.push_back(vv(1'b1, 32'h1122_3344, 32'd8, 8));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 12));        // fetch pc 12
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 13));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 14));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 15));
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 12));        // halt word
        tab.push_back(nv(1'b1, 1'b1, 32'd0, 1'b1, 1'b0, 12));        // redirect ignored
        tab.push_back(nv(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 12));
        tab.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 0, 1'b1));

        foreach (tab[i]) begin
            tick(tab[i].rst, tab[i].rdy, tab[i].rv, tab[i].tgt);
            check_out($sformatf("tab%0d", i), tab[i].valid, tab[i].ins, tab[i].ipc,
                      tab[i].h, tab[i].f, tab[i].addr, tab[i].chk_i);
        end

        // ---------------- reset in HOLD with redirect ----------------
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("hold_pre", 1'b1, 32'h2108_0002, 32'd0, 1'b0, 1'b0, 7'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        tick(1'b1, 1'b1, 1'b1, 32'd8);
        check_out("rst_hold", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("rst_restart", 1'b1, 32'h2108_0002, 32'd0, 1'b0, 1'b0, 7'd0, 1'b1);

        // ---------------- misaligned redirect -> fault ----------------
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 32'd6);
        check_out("mis_redir", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 7'd6, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("mis_fault", 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 7'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 1'b1, 32'd0);
            check_out($sformatf("mis_sticky%0d", i), 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 7'd6, 1'b0);
        end

        // ---------------- last legal word and first illegal one ----------------
        tick(1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 32'd124);
        check_out("end_redir", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 7'd124, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("end_word", 1'b1, 32'h5AA5_C33C, 32'd124, 1'b0, 1'b0, 7'd124, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 32'd128);
        check_out("past_redir", 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'd0);
        check_out("past_fault", 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 7'd0, 1'b0);

        // ---------------- randomized run against reference model ----------------
        for (int i = 0; i < MEMB; i++) mem[i] = 8'($urandom);
        for (int w = 0; w < MEMB / 4; w++) begin
            if ({mem[4*w], mem[4*w+1], mem[4*w+2], mem[4*w+3]} == HALT_W) mem[4*w] = 8'h80;
        end
        {mem[100], mem[101], mem[102], mem[103]} = HALT_W;

        m_pc = 32'd0; m_el = 0; m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic        r;
            logic        rd;
            logic        rv;
            logic [31:0] t;
            logic [6:0]  ea;
            int          sel;
            @(negedge clk);
            if (cyc == 0) r = 1'b1;
            else if (m_halt) r = ($urandom_range(0, 3) == 0);
            else r = ($urandom_range(0, 79) == 0);
            rd  = 1'($urandom_range(0, 1));
            rv  = ($urandom_range(0, 9) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       t = 32'($urandom_range(0, 31)) * 32'd4;
            else if (sel == 8) t = 32'($urandom_range(0, 127));
            else               t = 32'hFFFF_FFFC - 32'($urandom_range(0, 40)) * 32'd4;
            reset = r; instr_ready = rd; redirect_valid = rv; redirect_target = t;

            // model: effect of this cycle's inputs at the coming edge
            if (r) begin
                m_pc = 32'd0; m_el = 0; m_valid = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
            end else if (m_halt) begin
                m_halt = 1'b1;
            end else if (rv) begin
                m_pc = t; m_el = 0; m_valid = 1'b0;
            end else if (m_valid) begin
                if (rd) begin
                    m_pc = m_pc + 32'd4; m_el = 0; m_valid = 1'b0;
                end
            end else if (m_el == 0 && ((m_pc % 32'd4) != 32'd0 ||
                                       ({1'b0, m_pc} + 33'd3) >= 33'(MEMB))) begin
                m_halt = 1'b1; m_fault = 1'b1;
            end else begin
                m_el++;
                if (m_el == 4) begin
                    m_el = 0;
                    if (mem_word(m_pc) == HALT_W) m_halt = 1'b1;
                    else m_valid = 1'b1;
                end
            end

            @(posedge clk);
            #1;
            if (m_halt || m_valid) ea = m_pc[6:0];
            else ea = m_pc[6:0] + 7'(m_el);
            check_out($sformatf("rnd%0d", cyc), m_valid, mem_word(m_pc), m_pc,
                      m_halt, m_fault, ea, m_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter MEM_BYTES, 128: byte capacity of the instruction memory it addresses.
REQ-002 Parameter RESET_PC, 32'h0000_0000: PC loaded on reset.
REQ-003 Parameter HALT_WORD, 32'h0000_000C: instruction word that stops fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_addr  output  $clog2(MEM_BYTES)  byte address to instruction memory.
REQ-007 mem_data  input  8  byte read from instruction memory, combinational, same cycle as mem_addr.
REQ-008 instr  output  32  assembled instruction, big-endian (lowest address = bits 31:24).
REQ-009 instr_pc  output  32  byte address of instr.
REQ-010 instr_valid  output  1  instr/instr_pc are valid.
REQ-011 instr_ready  input  1  downstream accepts instr this cycle.
REQ-012 redirect_valid  input  1  branch/jump taken; load redirect_target.
REQ-013 redirect_target  input  32  new byte PC.
REQ-014 halt  output  1  sticky: fetch stopped.
REQ-015 fault  output  1  sticky: stopped due to bad PC.

Function
REQ-016 FSM states SHALL be FETCH, HOLD, HALT.
REQ-017 FETCH SHALL read one byte per cycle: mem_addr = pc + byte_cnt; byte_cnt 0..3.
REQ-018 Each FETCH cycle SHALL latch mem_data into instr bits [31-8*byte_cnt -: 8].
REQ-019 On the edge latching byte 3, FSM SHALL enter HOLD with instr_valid=1, instr_pc=pc; latency 4 cycles from FETCH entry to instr_valid.
REQ-020 In HOLD, instr and instr_pc SHALL stay stable until instr_ready=1.
REQ-021 HOLD with instr_ready=1 SHALL set pc=pc+4, byte_cnt=0, instr_valid=0 and enter FETCH on the same edge.
REQ-022 redirect_valid=1 in FETCH or HOLD SHALL set pc=redirect_target, byte_cnt=0, instr_valid=0 and enter FETCH; it overrides a simultaneous instr_ready, and the held instruction is dropped.
REQ-023 On FETCH entry with byte_cnt=0, pc[1:0]!=0 or pc+3>=MEM_BYTES SHALL enter HALT with halt=1, fault=1, with no memory read consumed.
REQ-024 An assembled word equal to HALT_WORD SHALL enter HALT with halt=1, fault=0, and SHALL NOT be presented (instr_valid stays 0).
REQ-025 HALT SHALL be absorbing; redirect_valid and instr_ready are ignored until reset.
REQ-026 In HOLD and HALT, mem_addr SHALL equal pc[$clog2(MEM_BYTES)-1:0].
REQ-027 pc arithmetic SHALL be 32-bit modulo 2^32; only the low address bits drive mem_addr.

Reset
REQ-028 reset=1 SHALL force state=FETCH, pc=RESET_PC, byte_cnt=0, instr=0, instr_pc=0, instr_valid=0, halt=0, fault=0 on the next edge.
REQ-029 Reset SHALL take priority over redirect, handshake and HALT, including in the middle of a fetch or HOLD.

Structure
REQ-030 Package fetch_pkg SHALL hold the state enum and the default HALT_WORD constant.
REQ-031 Byte assembly (shift-in register plus byte_cnt) SHALL be sub-module instr_assembler, with a clear input driven by reset/redirect/accept.

Verification
REQ-032 Memory bytes 21 08 00 02 01 0A 40 20, ready=1 after reset -> instr=0x21080002, instr_pc=0 valid on cycle 4; instr=0x010A4020, instr_pc=4 valid on cycle 9.
REQ-033 instr_ready=0 for 3 cycles in HOLD -> instr, instr_pc and instr_valid unchanged; accept on cycle 4 -> fetch of pc+4 begins on the next cycle.
REQ-034 redirect_valid with target 4 during byte_cnt=2 of the fetch at pc 8 -> partial word discarded; next valid instr=0x010A4020, instr_pc=4.
REQ-035 redirect_target=0x6 -> halt=1, fault=1, instr_valid=0 forever; a later redirect to 0 is ignored.
REQ-036 Bytes 00 00 00 0C at address 12 -> after that fetch halt=1, fault=0, instr_valid never asserts for pc 12.
REQ-037 reset asserted in HOLD with redirect_valid=1 -> next edge instr_valid=0, pc=0, halt=0; fetch restarts at RESET_PC.
